// File: rtl/dct_out_serializer.sv
// dct_out_serializer
//   Output stage of the DCT datapath. On the first cycle out_en is seen high
//   it captures every coefficient from the CORDIC bank. The bank delivers
//   them in bit-reversed lane order. Each coefficient is rescaled with
//   round-half-up and saturated, then streamed in natural order (X0..X15).
//   A one-cycle out_f pulse follows the last transfer.
//
// Handshake: a sample moves downstream on every rising edge where
//   dout_valid and dout_ready are both 1. While dout_valid=1 and
//   dout_ready=0, dout, dout_idx and dout_last stay constant. dout_valid
//   never waits on dout_ready. Dropping out_en mid-stream withdraws
//   dout_valid on the next cycle.
//
// Ports:
//   clk, reset        clock; synchronous active-high reset
//   clr               synchronous soft clear, same effect as reset
//   out_en            output-phase level from the control FSM
//   coef_in           DCT_POINT signed lanes of IN_W bits; lane j = X[bitrev(j)]
//   dout, dout_idx    current scaled coefficient and its index k
//   dout_valid        dout/dout_idx/dout_last are valid
//   dout_last         marks k = DCT_POINT-1
//   dout_ready        downstream accepts the current sample
//   out_f             one-cycle pulse: whole block transferred
//   dbg_state         current FSM state (IDLE=0, STREAM=1, DONE=2, HOLD=3)
module dct_out_serializer #(
    parameter int DCT_POINT = 16,
    parameter int IDX_W     = 4,
    parameter int IN_W      = 18,
    parameter int OUT_W     = 16,
    parameter int SHIFT     = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      clr,
    input  logic                      out_en,
    input  logic [DCT_POINT*IN_W-1:0] coef_in,
    output logic [OUT_W-1:0]          dout,
    output logic [IDX_W-1:0]          dout_idx,
    output logic                      dout_valid,
    output logic                      dout_last,
    input  logic                      dout_ready,
    output logic                      out_f,
    output logic [1:0]                dbg_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2,
        HOLD   = 2'd3
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DCT_POINT - 1);

    // Rounding constant and saturation limits, all in IN_W+1 bits.
    localparam logic signed [IN_W:0] RND   = (IN_W+1)'(2 ** (SHIFT - 1));
    localparam logic signed [IN_W:0] MAX_V = (IN_W+1)'((2 ** (OUT_W - 1)) - 1);
    localparam logic signed [IN_W:0] MIN_V = -((IN_W+1)'(2 ** (OUT_W - 1)));

    state_t           state, state_nxt;
    logic [IDX_W-1:0] idx, idx_nxt;
    logic             capture;
    logic [IN_W-1:0]  coef_buf [DCT_POINT];

    logic [IN_W-1:0]  sel;
    logic signed [IN_W:0] sum_w;
    logic signed [IN_W:0] shr_w;

    function automatic logic [IDX_W-1:0] bit_rev(input logic [IDX_W-1:0] v);
        logic [IDX_W-1:0] r;
        for (int i = 0; i < IDX_W; i++) begin
            r[i] = v[IDX_W-1-i];
        end
        return r;
    endfunction

    // State, index and coefficient buffer.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            state <= IDLE;
            idx   <= '0;
            for (int j = 0; j < DCT_POINT; j++) begin
                coef_buf[j] <= '0;
            end
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            if (capture) begin
                for (int j = 0; j < DCT_POINT; j++) begin
                    coef_buf[j] <= coef_in[j*IN_W +: IN_W];
                end
            end
        end
    end

    // Next-state and control outputs.
    always_comb begin
        state_nxt  = state;
        idx_nxt    = idx;
        capture    = 1'b0;
        dout_valid = 1'b0;
        dout_last  = 1'b0;
        out_f      = 1'b0;
        case (state)
            IDLE: begin
                if (out_en) begin
                    capture   = 1'b1;
                    idx_nxt   = '0;
                    state_nxt = STREAM;
                end
            end
            STREAM: begin
                dout_valid = 1'b1;
                dout_last  = (idx == LAST_IDX);
                if (!out_en) begin
                    // Abort takes priority over any handshake in this cycle.
                    state_nxt = IDLE;
                end else if (dout_ready) begin
                    if (idx == LAST_IDX) begin
                        state_nxt = DONE;
                    end else begin
                        idx_nxt = idx + 1'b1;
                    end
                end
            end
            DONE: begin
                out_f     = 1'b1;
                state_nxt = HOLD;
            end
            HOLD: begin
                // Block recapture until the control FSM drops out_en.
                if (!out_en) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Coefficient k lives in lane bitrev(k). dout depends only on the buffer
    // and idx, so it is stable whenever idx holds.
    always_comb begin
        sel   = coef_buf[bit_rev(idx)];
        sum_w = $signed({sel[IN_W-1], sel}) + RND;
        shr_w = sum_w >>> SHIFT;
        if (shr_w > MAX_V) begin
            dout = MAX_V[OUT_W-1:0];
        end else if (shr_w < MIN_V) begin
            dout = MIN_V[OUT_W-1:0];
        end else begin
            dout = shr_w[OUT_W-1:0];
        end
    end

    assign dout_idx  = idx;
    assign dbg_state = state;

endmodule

// File: tb/tb_dct_out_serializer.sv
// tb_dct_out_serializer
//   Directed bench for dct_out_serializer. Stimulus tasks push the expected
//   {last, idx, dout} of every transfer into exp_q. A negedge monitor pops
//   and compares on each handshake. It also checks that stalled outputs
//   hold and that out_f is a single-cycle pulse.
module tb_dct_out_serializer;

    localparam int DCT_POINT = 16;
    localparam int IDX_W     = 4;
    localparam int IN_W      = 18;
    localparam int OUT_W     = 16;
    localparam int SHIFT     = 2;
    localparam int EXP_W     = 1 + IDX_W + OUT_W;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                      reset;
    logic                      clr;
    logic                      out_en;
    logic [DCT_POINT*IN_W-1:0] coef_in;
    logic [OUT_W-1:0]          dout;
    logic [IDX_W-1:0]          dout_idx;
    logic                      dout_valid;
    logic                      dout_last;
    logic                      dout_ready;
    logic                      out_f;
    logic [1:0]                dbg_state;

    dct_out_serializer #(
        .DCT_POINT(DCT_POINT), .IDX_W(IDX_W), .IN_W(IN_W),
        .OUT_W(OUT_W), .SHIFT(SHIFT)
    ) dut (
        .clk(clk), .reset(reset), .clr(clr), .out_en(out_en),
        .coef_in(coef_in), .dout(dout), .dout_idx(dout_idx),
        .dout_valid(dout_valid), .dout_last(dout_last),
        .dout_ready(dout_ready), .out_f(out_f), .dbg_state(dbg_state)
    );

    // ---------------- bookkeeping ----------------
    int total = 0;
    int bad   = 0;
    int xfer_cnt = 0;
    int outf_cnt = 0;
    logic [EXP_W-1:0] exp_q[$];
    logic signed [IN_W-1:0] coef_k [DCT_POINT];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [IDX_W-1:0] brev(input logic [IDX_W-1:0] v);
        logic [IDX_W-1:0] r;
        for (int i = 0; i < IDX_W; i++) r[i] = v[IDX_W-1-i];
        return r;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Places coefficient k in lane bitrev(k), as the CORDIC bank does.
    task automatic pack_coefs();
        for (int k = 0; k < DCT_POINT; k++) begin
            coef_in[brev(IDX_W'(k))*IN_W +: IN_W] = coef_k[k];
        end
    endtask

    task automatic push_exp(input int k, input logic [OUT_W-1:0] val);
        exp_q.push_back({(k == DCT_POINT - 1), IDX_W'(k), val});
    endtask

    // Ramp: X[k] = 4k, scaled result k.
    task automatic setup_ramp(input int n_exp);
        for (int k = 0; k < DCT_POINT; k++) coef_k[k] = IN_W'(4 * k);
        for (int k = 0; k < n_exp; k++) push_exp(k, OUT_W'(k));
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_valid"}, 32'(dout_valid), 0);
        check({tag, "_out_f"}, 32'(out_f), 0);
    endtask

    // Runs one full block with ready at `duty` percent, then holds out_en
    // three cycles past out_f before releasing it.
    task automatic run_block(input int duty, input bit check_lat);
        int x0, f0, n;
        x0 = xfer_cnt;
        f0 = outf_cnt;
        pack_coefs();
        check("pre_capture_valid", 32'(dout_valid), 0);
        out_en = 1'b1;
        step();
        check("first_valid", 32'(dout_valid), 1);
        n = 0;
        while (!out_f && n < 2000) begin
            dout_ready = ($urandom_range(0, 99) < duty);
            step();
            n++;
        end
        if (n >= 2000) begin
            total++;
            bad++;
            $display("FAIL block_timeout: out_f not seen after %0d cycles", n);
        end
        if (check_lat) check("outf_latency", 32'(n), 16);
        check("xfer_count", 32'(xfer_cnt - x0), 16);
        check("queue_empty", 32'(exp_q.size()), 0);
        dout_ready = 1'b0;
        coef_in = '1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_idle_outputs("hold");
        end
        out_en = 1'b0;
        step();
        step();
        check("outf_count", 32'(outf_cnt - f0), 1);
        check_idle_outputs("rearm");
    endtask

    // ---------------- scoreboard monitor ----------------
    logic             stalled_prev = 1'b0;
    logic             outf_prev = 1'b0;
    logic [OUT_W-1:0] dout_prev;
    logic [IDX_W-1:0] idx_prev;

    always @(negedge clk) begin
        logic [EXP_W-1:0] e;
        if (dout_valid && stalled_prev) begin
            check("stall_dout", 32'(dout), 32'(dout_prev));
            check("stall_idx", 32'(dout_idx), 32'(idx_prev));
        end
        if (dout_valid && dout_ready && out_en && !reset && !clr) begin
            xfer_cnt++;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_xfer: idx=%0d dout=%0h", dout_idx, dout);
            end else begin
                e = exp_q.pop_front();
                check("xfer", 32'({dout_last, dout_idx, dout}), 32'(e));
            end
        end
        if (out_f) begin
            outf_cnt++;
            check("outf_single", 32'(outf_prev), 0);
        end
        stalled_prev = dout_valid && !dout_ready && out_en && !reset && !clr;
        outf_prev    = out_f;
        dout_prev    = dout;
        idx_prev     = dout_idx;
    end

    // Mid-stream reset or clear at k=7.
    task automatic mid_clear(input bit use_clr);
        setup_ramp(7);
        pack_coefs();
        out_en = 1'b1;
        dout_ready = 1'b1;
        step();
        repeat (7) step();
        check("at_k7_idx", 32'(dout_idx), 7);
        if (use_clr) clr = 1'b1; else reset = 1'b1;
        dout_ready = 1'b0;
        out_en = 1'b0;
        step();
        check("clear_dout", 32'(dout), 0);
        check("clear_idx", 32'(dout_idx), 0);
        check("clear_valid", 32'(dout_valid), 0);
        check("clear_last", 32'(dout_last), 0);
        check("clear_out_f", 32'(out_f), 0);
        reset = 1'b0;
        clr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check_idle_outputs("post_clear");
        end
        check("clear_queue", 32'(exp_q.size()), 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int f0;
        reset = 1'b1;
        clr = 1'b0;
        out_en = 1'b0;
        dout_ready = 1'b0;
        coef_in = '0;
        repeat (3) step();
        check("rst_dout", 32'(dout), 0);
        check("rst_idx", 32'(dout_idx), 0);
        check("rst_valid", 32'(dout_valid), 0);
        check("rst_last", 32'(dout_last), 0);
        check("rst_out_f", 32'(out_f), 0);
        reset = 1'b0;
        step();

        // Ramp with ready held high: dout = k.
        setup_ramp(16);
        run_block(100, 1'b1);

        // Rounding / saturation: X0=+6, X8=-6, X4=max, X12=min.
        for (int k = 0; k < DCT_POINT; k++) coef_k[k] = '0;
        coef_k[0]  = 18'sd6;
        coef_k[8]  = -18'sd6;
        coef_k[4]  = 18'sd131071;
        coef_k[12] = -18'sd131072;
        for (int k = 0; k < DCT_POINT; k++) begin
            case (k)
                0:       push_exp(k, 16'h0002);
                4:       push_exp(k, 16'h7FFF);
                8:       push_exp(k, 16'hFFFF);
                12:      push_exp(k, 16'h8000);
                default: push_exp(k, 16'h0000);
            endcase
        end
        run_block(100, 1'b0);

        // Backpressure at 30%: X[k] = -8k-3, scaled result -2k-1.
        for (int k = 0; k < DCT_POINT; k++) begin
            coef_k[k] = IN_W'(-8 * k - 3);
            push_exp(k, OUT_W'(-2 * k - 1));
        end
        run_block(30, 1'b0);

        // Abort after 5 transfers, then a full restart from k=0.
        f0 = outf_cnt;
        setup_ramp(5);
        pack_coefs();
        out_en = 1'b1;
        dout_ready = 1'b1;
        step();
        repeat (5) step();
        out_en = 1'b0;
        dout_ready = 1'b0;
        step();
        check("abort_valid", 32'(dout_valid), 0);
        check("abort_queue", 32'(exp_q.size()), 0);
        repeat (3) step();
        check("abort_no_outf", 32'(outf_cnt - f0), 0);
        setup_ramp(16);
        run_block(100, 1'b1);

        // Reset, then clear, at k=7; each followed by a clean block.
        mid_clear(1'b0);
        setup_ramp(16);
        run_block(100, 1'b1);
        mid_clear(1'b1);
        setup_ramp(16);
        run_block(60, 1'b0);

        repeat (2) step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dct_out_serializer.md
# dct_out_serializer

Output stage of the 16-point DCT datapath, directly downstream of the control FSM's output phase. When `out_en` rises, it captures all `DCT_POINT` coefficients from the CORDIC rotation bank in one cycle. The bank delivers coefficients in bit-reversed lane order. The block rescales and saturates each coefficient, then streams them in natural order (X0..X15) over a valid/ready interface. After the last transfer it returns a one-cycle `out_f` pulse to the control FSM.

## Interface
Parameters:
- `DCT_POINT`, 16, number of coefficients per block; power of two
- `IDX_W`, 4, log2(`DCT_POINT`)
- `IN_W`, 18, width of each signed coefficient from the CORDIC bank
- `OUT_W`, 16, width of each signed output sample
- `SHIFT`, 2, right-shift applied with rounding; `IN_W - SHIFT >= OUT_W`

Ports:
- `clk`, in, 1, clock; all logic on rising edge
- `reset`, in, 1, reset: synchronous, active-high
- `clr`, in, 1, synchronous soft clear from the control FSM; same effect as `reset`
- `out_en`, in, 1, level from the control FSM, high for the whole output phase
- `coef_in`, in, `DCT_POINT*IN_W`, signed lanes; lane j occupies bits [j*IN_W +: IN_W] and holds coefficient bitrev(j)
- `dout`, out, `OUT_W`, current output coefficient, signed
- `dout_idx`, out, `IDX_W`, index k of the coefficient on `dout`
- `dout_valid`, out, 1, `dout`, `dout_idx` and `dout_last` are valid
- `dout_last`, out, 1, high with `dout_valid` when k = `DCT_POINT-1`
- `dout_ready`, in, 1, downstream accepts the current sample
- `out_f`, out, 1, one-cycle pulse: block fully transferred

## Operation
- States: IDLE, STREAM, DONE, HOLD.
- IDLE:
  - If `out_en`=1: register all lanes of `coef_in` into `buf`, set idx=0 and go to STREAM.
  - Otherwise stay in IDLE.
- STREAM:
  - `dout_valid`=1.
  - `dout` = scale(`buf`[bitrev(idx)]); `dout_idx`=idx; `dout_last`=(idx==`DCT_POINT-1`).
  - A transfer occurs on a cycle where `dout_valid` and `dout_ready` are both 1.
  - On a transfer with idx < `DCT_POINT-1`: idx++.
  - On a transfer with idx == `DCT_POINT-1`: go to DONE.
- DONE: `out_f`=1 for exactly one cycle, then go to HOLD.
- HOLD: wait for `out_en`=0, then go to IDLE. This prevents a recapture while `out_en` is still high after `out_f`.
- scale(x):
  - r = (x + 2^(`SHIFT`-1)) >>> `SHIFT`, computed in `IN_W+1` bits. Rounding is half toward +inf.
  - Saturate r to [-2^(`OUT_W`-1), 2^(`OUT_W`-1)-1].
- `dout` is combinational from `buf` and idx; it changes only when idx changes.
- Abort: if `out_en`=0 in STREAM, go to IDLE next cycle. No `out_f` is issued and no further transfers occur.
- `reset` or `clr` at any time, including mid-stream:
  - state=IDLE, idx=0, `buf`=0.
  - `dout_valid`=0, `dout_last`=0, `out_f`=0, `dout`=0, `dout_idx`=0.
  - `reset`/`clr` takes priority over `out_en`.
- Backpressure has no limit: `dout_ready` may stay low indefinitely, and outputs must stay stable while `dout_valid`=1 and `dout_ready`=0.

## Timing
- Reset values: all outputs 0.
- `out_en` first sampled high at edge E: capture occurs at E, and `dout_valid`=1 from the cycle after E.
- With `dout_ready` held at 1: 16 consecutive transfers, then `out_f` in the cycle after the last transfer.
  - Total from first `dout_valid` to `out_f`: `DCT_POINT`+1 cycles.
- `out_f` lasts exactly one cycle. The control FSM samples it and drops `out_en` on the following cycle; HOLD covers that gap.
- Minimum re-arm: IDLE is entered one cycle after `out_en` is sampled low.
- `coef_in` is sampled only at the capture edge and may change freely afterwards.

## Test plan
- Ramp stream:
  - Stimulus: lane j = bitrev(j)*4, `SHIFT`=2, `dout_ready`=1.
  - Required: `dout` = 0,1,...,15 with `dout_idx`=0..15; `dout_last` only at k=15; `out_f` one cycle after k=15; first `dout_valid` one cycle after `out_en`.
- Rounding and saturation:
  - Stimulus: lanes 0..3 = +6, -6, 131071, -131072.
  - Required: X0=2, X8=-1, X4=32767, X12=-32768.
- Backpressure:
  - Stimulus: random `dout_ready` at 30% duty.
  - Required: `dout` and `dout_idx` held stable while stalled; exactly 16 transfers, in order; a single `out_f` pulse.
- Abort:
  - Stimulus: drop `out_en` after 5 transfers.
  - Required: `dout_valid`=0 next cycle; no `out_f`; re-raising `out_en` recaptures and restarts at k=0.
- Reset and clear mid-stream:
  - Stimulus: assert `reset` at k=7; separately, assert `clr` at k=7.
  - Required: all outputs 0 on the next cycle; no stream until a new `out_en`.
- No double capture:
  - Stimulus: hold `out_en` high for 3 cycles after `out_f`.
  - Required: `dout_valid` stays 0 and no second `out_f` occurs.
